// File: rtl/result_display_if.sv
// Result-word handshake between the divider side and the display block.
interface result_display_if;
    logic       load;
    logic [5:0] value;
    logic       split;
    logic       busy;
    logic       valid;

    modport master (output load, output value, output split, input busy, input valid);
    modport slave  (input load, input value, input split, output busy, output valid);
endinterface

// File: rtl/result_display.sv
// Captures the divider result word, converts it to BCD, and drives a 4-digit muxed 7-seg display.
// Digits update 7 cycles after load; loads seen while busy (including the COMMIT cycle) are dropped.
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    result_display_if.slave   bus,
    output logic [3:0]        an,
    output logic [6:0]        sseg
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [5:0]  shadow;
    logic        shadow_split;
    logic [5:0]  sh;
    logic [7:0]  bcd;
    logic [7:0]  bcd_adj;
    logic [13:0] dd_next;
    logic [2:0]  iter;
    logic        valid_q;
    logic [4:0]  dig [4];   // {blank, code}
    logic [CW-1:0] cnt;
    logic [1:0]  idx;
    logic [4:0]  cur;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0: seg_lut = 7'b1000000;
            4'd1: seg_lut = 7'b1111001;
            4'd2: seg_lut = 7'b0100100;
            4'd3: seg_lut = 7'b0110000;
            4'd4: seg_lut = 7'b0011001;
            4'd5: seg_lut = 7'b0010010;
            4'd6: seg_lut = 7'b0000010;
            4'd7: seg_lut = 7'b1111000;
            4'd8: seg_lut = 7'b0000000;
            4'd9: seg_lut = 7'b0010000;
            default: seg_lut = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = CONVERT;
            CONVERT: if (iter == 3'd0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != IDLE);
        bus.valid = valid_q;
    end

    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        dd_next = {bcd_adj, sh} << 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow       <= '0;
            shadow_split <= 1'b0;
            sh           <= '0;
            bcd          <= '0;
            iter         <= '0;
            valid_q      <= 1'b0;
            for (int i = 0; i < 4; i++) dig[i] <= 5'b1_0000;
        end else begin
            case (state)
                IDLE: if (bus.load) begin
                    shadow       <= bus.value;
                    shadow_split <= bus.split;
                    sh           <= bus.value;
                    bcd          <= '0;
                    iter         <= 3'd5;
                end
                CONVERT: begin
                    {bcd, sh} <= dd_next;
                    iter      <= iter - 3'd1;
                end
                COMMIT: begin
                    valid_q <= 1'b1;
                    dig[2]  <= 5'b1_0000;
                    dig[3]  <= 5'b1_0000;
                    if (shadow_split) begin
                        dig[0] <= {2'b00, shadow[5:3]};
                        dig[1] <= {2'b00, shadow[2:0]};
                    end else begin
                        dig[0] <= {1'b0, bcd[3:0]};
                        dig[1] <= {(bcd[7:4] == 4'd0), bcd[7:4]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Refresh scan runs regardless of conversion activity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        cur  = dig[idx];
        an   = cur[4] ? 4'b1111 : ~(4'b0001 << idx);
        sseg = (cur[4] || !valid_q) ? 7'b1111111 : seg_lut(cur[3:0]);
    end
endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Downstream consumer of the ALU divider's 6-bit result word: {remainder[5:3], quotient[2:0]}.
- Captures the word on a load strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit, time-multiplexed, common-anode 7-segment display on the lab board.
- Supports two modes: the whole word as an unsigned decimal, or quotient and remainder as separate digits.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is held active before advancing to the next digit (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; capture value and split.
- value  input  6  result word; [5:3] = remainder, [2:0] = quotient.
- split  input  1  0 = show value as decimal 0..63; 1 = show quotient and remainder separately.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  high once at least one conversion has completed since reset.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- sseg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - FSM returns to IDLE; busy=0, valid=0.
  - an=4'b1111, sseg=7'b1111111.
  - Digit registers blanked; refresh counter and digit index cleared to 0.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: when load=1, latch value and split into shadow registers, clear the BCD scratch register (8 bits: tens, units), set iter=5, go to CONVERT. busy rises on the same edge.
  - CONVERT: one double-dabble step per cycle.
    - Add 3 to each BCD nibble that is >=5.
    - Shift {bcd, shadow} left by 1.
    - Decrement iter; after the step where iter=0, go to COMMIT. Exactly 6 cycles.
  - COMMIT: write the display digit registers, set valid=1, clear busy, return to IDLE.
- Latency: load sampled at edge N; busy=1 from N through N+6; new digits appear and busy=0 at edge N+7.
- load while busy=1 is ignored; no queueing. A load arriving in the same cycle busy falls is also ignored. It is accepted on the next cycle spent in IDLE.
- Digit mapping:
  - split=0: digit0 = units; digit1 = tens, blanked if tens=0; digits 2 and 3 blanked.
  - split=1: digit0 = remainder (value[5:3]); digit1 = quotient (value[2:0]); digits 2 and 3 blanked. The conversion engine still runs, so latency is identical in both modes; its BCD result is discarded.
- Display refresh (free-running from reset deassertion, independent of the FSM):
  - The counter runs 0..REFRESH_DIV-1. On wrap, digit index increments mod 4 (3 wraps to 0).
  - The anode of the current index is driven low only if that digit is non-blank; otherwise an=4'b1111 for that slot.
  - sseg shows the current digit's pattern; it is 7'b1111111 when the digit is blank or valid=0.
- Display digits hold their last value during a new conversion and change only at COMMIT.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset during CONVERT aborts immediately. Outputs return to reset values and no partial digits are committed.
- Widths: the BCD scratch register is 8 bits; the maximum result is 63, so the tens nibble never exceeds 6. The refresh counter is $clog2(REFRESH_DIV) bits.

Test Plan:
- Reset then idle 20 cycles -> an=1111, sseg=1111111, valid=0, busy=0.
- split=0, value=63, load pulse at edge N (REFRESH_DIV=4) -> busy high edges N..N+6; at N+7 valid=1; digit0 slot shows sseg=0110000 ("3"); digit1 slot shows 0000010 ("6"); slots 2 and 3 show an=1111.
- split=0, value=5 -> digit0=0010010 ("5"); tens blanked, so the digit1 slot shows an=1111.
- split=1, value=6'b001_011 (7/2: quotient 3, remainder 1) -> digit1=0110000 ("3"), digit0=1111001 ("1"), latency still 7.
- load=1 with value=9, then a second load with value=42 at N+3 -> 42 ignored; display shows 9 after N+7. Then load 42 in IDLE -> tens=4, units=2.
- Assert reset at N+3 mid-conversion -> outputs immediately return to reset values; after release, valid=0 and the old digits do not reappear.
